hazard_ctrl: RTL

- Pipeline hazard and forwarding controller: the consumer and controller end of the ID/EX stage register.
- Reads ID/EX contents plus the EX/MEM and MEM/WB destinations.
- Drives PC and IF/ID write enables, the ID/EX bubble and flushes, and the EX-stage forwarding selects.
- Holds a small FSM for multi-cycle load-use stalls and branch flush penalties, plus saturating event counters.

---
 rtl/hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline hazard and forwarding controller. It detects
//                load-use hazards between ID/EX and IF/ID, inserts a
//                configurable number of bubbles, flushes the front end after
//                a taken branch and selects the EX-stage forwarding sources.
//                Saturating counters record stall cycles and branch flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int LOAD_LATENCY   = 1,   // bubble cycles per load-use hazard (1..7)
  parameter int BRANCH_PENALTY = 1,   // flush cycles per taken branch (1..7)
  parameter int CNT_W          = 16   // statistics counter width
) (
  input  logic             clk,
  input  logic             reset,
  // IF/ID source fields
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  // ID/EX contents
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memRead,
  // Later-stage destinations
  input  logic             exmem_regWrite,
  input  logic [4:0]       exmem_dest,
  input  logic             memwb_regWrite,
  input  logic [4:0]       memwb_dest,
  // Branch resolution in EX
  input  logic             ex_branch_taken,
  // Pipeline control
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  // Statistics
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_LSTALL = 2'd1;
  localparam logic [1:0] S_BFLUSH = 2'd2;

  // Forwarding select encodings
  localparam logic [1:0] c_fwd_rf    = 2'b00;
  localparam logic [1:0] c_fwd_exmem = 2'b10;
  localparam logic [1:0] c_fwd_memwb = 2'b01;

  // Remaining-cycle reload values loaded when entering a multi-cycle state.
  // The first stall/flush cycle is spent in RUN, so the counter holds N-1.
  localparam logic [2:0] c_load_reload   = 3'(LOAD_LATENCY - 1);
  localparam logic [2:0] c_branch_reload = 3'(BRANCH_PENALTY - 1);
  localparam bit         c_load_multi    = (LOAD_LATENCY > 1);
  localparam bit         c_branch_multi  = (BRANCH_PENALTY > 1);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // --------------------------------------------------------------------------
  // State and wires
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [2:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  logic [1:0]       w_next_state;
  logic [2:0]       w_next_cnt;
  logic             w_luh;
  logic             w_flush_accept;

  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_idex_bubble;
  logic             w_ifid_flush;
  logic             w_idex_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // --------------------------------------------------------------------------
  // Load-use detection: the load in ID/EX writes a register the IF/ID
  // instruction reads. $0 is hard-wired to zero and never creates a hazard.
  // --------------------------------------------------------------------------
  always_comb begin
    w_luh = idex_memRead && (idex_rt != 5'd0) &&
            ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  end

  // --------------------------------------------------------------------------
  // Forwarding select for one EX operand; the youngest producer wins.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (exmem_regWrite && (exmem_dest != 5'd0) && (exmem_dest == src)) begin
      fwd_sel = c_fwd_exmem;
    end else if (memwb_regWrite && (memwb_dest != 5'd0) && (memwb_dest == src)) begin
      fwd_sel = c_fwd_memwb;
    end else begin
      fwd_sel = c_fwd_rf;
    end
  endfunction

  // Forwarding selects, independent of the stall/flush FSM
  always_comb begin
    w_fwd_a = fwd_sel(idex_rs);
    w_fwd_b = fwd_sel(idex_rt);
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state logic. A taken branch preempts a pending load stall, since
  // the stalled instructions are squashed anyway; BFLUSH ignores new branches
  // because ID/EX only holds a bubble there.
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      S_RUN: begin
        if (ex_branch_taken) begin
          if (c_branch_multi) begin
            w_next_state = S_BFLUSH;
            w_next_cnt   = c_branch_reload;
          end
        end else if (w_luh) begin
          if (c_load_multi) begin
            w_next_state = S_LSTALL;
            w_next_cnt   = c_load_reload;
          end
        end
      end
      S_LSTALL: begin
        if (ex_branch_taken) begin
          if (c_branch_multi) begin
            w_next_state = S_BFLUSH;
            w_next_cnt   = c_branch_reload;
          end else begin
            w_next_state = S_RUN;
            w_next_cnt   = 3'd0;
          end
        end else if (r_cnt <= 3'd1) begin
          w_next_state = S_RUN;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_cnt   = r_cnt - 3'd1;
        end
      end
      S_BFLUSH: begin
        if (r_cnt <= 3'd1) begin
          w_next_state = S_RUN;
          w_next_cnt   = 3'd0;
        end else begin
          w_next_cnt   = r_cnt - 3'd1;
        end
      end
      default: begin
        w_next_state = S_RUN;
        w_next_cnt   = 3'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM output logic (combinational; takes effect at the next edge)
  // --------------------------------------------------------------------------
  always_comb begin
    w_pc_write     = 1'b1;
    w_ifid_write   = 1'b1;
    w_idex_bubble  = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_flush   = 1'b0;
    w_flush_accept = 1'b0;
    case (r_state)
      S_RUN, S_LSTALL: begin
        if (ex_branch_taken) begin
          w_ifid_flush   = 1'b1;
          w_idex_flush   = 1'b1;
          w_flush_accept = 1'b1;
        end else if (w_luh || (r_state == S_LSTALL)) begin
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
        end
      end
      S_BFLUSH: begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
      end
      default: begin
        w_pc_write = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Saturating statistics counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != c_cnt_max)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_flush_accept && (r_flush_events != c_cnt_max)) begin
        r_flush_events <= r_flush_events + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive: while reset is held the pipeline runs freely with no
  // stalls, flushes or forwarding.
  // --------------------------------------------------------------------------
  always_comb begin
    if (reset) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      forward_a   = c_fwd_rf;
      forward_b   = c_fwd_rf;
    end else begin
      pc_write    = w_pc_write;
      ifid_write  = w_ifid_write;
      idex_bubble = w_idex_bubble;
      ifid_flush  = w_ifid_flush;
      idex_flush  = w_idex_flush;
      forward_a   = w_fwd_a;
      forward_b   = w_fwd_b;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;

endmodule
`default_nettype wire
